// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: three requesters share one UART transmitter, round-robin arbitrated, 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_scheduler #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       uart_tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bit_n, gnt_n;
  logic [7:0] sh, sh_n;
  logic [1:0] ptr, ptr_n, p1, p2, win;
  logic wrap, tx_n;
  assign p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
  assign p2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
  assign win = req[ptr] ? ptr : req[p1] ? p1 : p2;
  assign wrap = cnt == LAST;
  assign busy = state != IDLE;
  // The shifter rotates, so after eight bits it holds the original byte again.
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bit_n = bit_cnt;
    sh_n = sh;
    ptr_n = ptr;
    gnt_n = 3'b000;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|req) begin
          state_n = START;
          sh_n = win == 2'd0 ? data0 : win == 2'd1 ? data1 : data2;
          ptr_n = win == 2'd2 ? 2'd0 : win + 2'd1;
          gnt_n = 3'b001 << win;
        end
      end
      START: if (wrap) begin
        state_n = DATA;
        cnt_n = '0;
        bit_n = '0;
      end
      DATA: if (wrap) begin
        cnt_n = '0;
        sh_n = {sh[0], sh[7:1]};
        bit_n = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_cnt == 3'd7) state_n = PARITY;
`else
        if (bit_cnt == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (wrap) begin
        state_n = STOP;
        cnt_n = '0;
      end
`endif
      STOP: if (wrap) begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef UART_TX_PARITY_EN
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? ^sh_n : 1'b1;
`else
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`endif
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      ptr <= '0;
      gnt <= '0;
      uart_tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      uart_tx <= tx_n;
    end
  end
endmodule
